apb_front_arbiter: RTL
======================

Name: apb_front_arbiter

Overview:
- Shares the single APB requester front-end (transfer/write/addr/wdata/rdata/ready) between NUM_MST upstream masters, e.g. CPU bus bridge and UART DMA.
- Runs a round-robin arbiter with a per-master valid/ready request handshake and a one-cycle response pulse.
- Sequences the requester's IDLE→SETUP→ACCESS phases so that only one transfer is in flight at a time.
- Drives `transfer` for exactly one cycle per transaction.

Parameters:
- NUM_MST, 2, number of upstream masters (2..8).
- ADDR_WIDTH, 32, address width; same as the bus package.
- DATA_WIDTH, 32, data width; same as the bus package.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- s_req_valid  in  NUM_MST  per-master request valid.
- s_req_write  in  NUM_MST  per-master write flag (1 = write).
- s_req_addr  in  NUM_MST*ADDR_WIDTH  per-master address; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_req_wdata  in  NUM_MST*DATA_WIDTH  per-master write data, sliced the same way.
- s_req_ready  out  NUM_MST  one-hot accept strobe.
- s_rsp_valid  out  NUM_MST  one-hot completion pulse.
- s_rsp_rdata  out  DATA_WIDTH  read data; valid while s_rsp_valid is nonzero.
- m_transfer  out  1  to requester `transfer`.
- m_write  out  1  to requester `write`.
- m_addr  out  ADDR_WIDTH  to requester `addr`.
- m_wdata  out  DATA_WIDTH  to requester `wdata`.
- m_rdata  in  DATA_WIDTH  from requester `rdata` (PRDATA).
- m_ready  in  1  from requester `ready` (PREADY).
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_MST)  index of the current or last granted master.

Behaviour:
- Reset, asynchronous:
  - state = IDLE, rr_ptr = 0, grant_id = 0.
  - All m_* outputs = 0, s_rsp_valid = 0, s_rsp_rdata = 0, busy = 0.
  - s_req_ready is combinational and therefore 0 in reset.
- FSM states: IDLE, ISSUE, SETUP, ACCESS.
- IDLE:
  - Winner = first master with s_req_valid=1, searching from rr_ptr upward with wrap.
  - s_req_ready[winner] = 1 combinationally in this same cycle; all other bits are 0.
  - On the clock edge: register winner's write/addr/wdata into m_write/m_addr/m_wdata, grant_id = winner, rr_ptr = (winner+1) mod NUM_MST, go to ISSUE.
  - No valid requests: stay in IDLE; m_* outputs hold their previous values and m_transfer = 0.
- ISSUE:
  - m_transfer = 1, registered, exactly one cycle.
  - Requester samples the command here.
  - Next state is SETUP.
- SETUP:
  - m_transfer = 0.
  - m_ready is ignored, because a slave may hold PREADY high outside the access phase.
  - Next state is ACCESS.
- ACCESS:
  - m_transfer = 0, which returns the requester to its IDLE after completion.
  - m_ready = 0: stay in ACCESS. Wait states are unbounded; there is no timeout.
  - m_ready = 1: on that edge, s_rsp_valid[grant_id] = 1 for one cycle and s_rsp_rdata = m_rdata, captured for both reads and writes; go to IDLE.
- Latency:
  - Accept at cycle T, m_transfer at T+1.
  - Zero-wait completion: s_rsp_valid at T+4, coinciding with IDLE.
  - A new accept may occur in that same T+4 cycle.
  - Each slave wait state adds 1 cycle.
- Masters:
  - Must hold valid and payload stable until s_req_ready.
  - Must not issue a new request before their s_rsp_valid.
  - Deasserting valid before accept is legal; such a master is simply not granted.
- s_rsp_rdata holds its value after the pulse until the next completion.
- m_write/m_addr/m_wdata stay stable from ISSUE through the end of ACCESS.
- Simultaneous requests: round-robin order from rr_ptr. With 2 masters both always requesting, grants alternate 0,1,0,1.
- Reset asserted mid-transaction: immediate return to IDLE and no s_rsp_valid is generated. The requester shares PRESETn and resets together with this block.

Test Plan:
- Single write, master 0: addr=0x1000_1004, wdata=0xA5A5_0001, m_ready=1 throughout. Expect s_req_ready[0] at T, m_transfer=1 only at T+1 with m_addr=0x1000_1004, s_rsp_valid=2'b01 at T+4.
- Single read, master 1: addr=0x1000_0010; slave returns m_rdata=0xDEAD_BEEF with m_ready=1 in ACCESS. Expect s_rsp_valid=2'b10 and s_rsp_rdata=0xDEAD_BEEF at T+4; grant_id=1.
- Wait states: m_ready held 0 for 3 ACCESS cycles. Expect s_rsp_valid at T+7. m_ready=1 during SETUP must not complete the transaction early.
- Contention: masters 0 and 1 both continuously valid for 4 transactions from reset. Expect grant order 0,1,0,1, each accept exactly 4 cycles apart with zero wait, and never two m_transfer pulses closer than 4 cycles.
- Reset mid-ACCESS: PRESETn low for 2 cycles while in ACCESS. Expect busy=0 and all outputs 0 immediately, no s_rsp_valid, and rr_ptr=0 afterwards, so master 0 wins the next contention.
- Idle hold: no requests for 10 cycles. Expect m_transfer=0, busy=0, and m_addr unchanged from the last transaction.

Source files
------------

// File: rtl/apb_front_arbiter.sv
// apb_front_arbiter
//   Shares one APB requester front-end between NUM_MST upstream masters.
//   A round-robin arbiter grants one request at a time. The block then
//   drives the requester through ISSUE/SETUP/ACCESS and returns a one-cycle
//   completion pulse to the granted master.
// Ports
//   PCLK, PRESETn          clock, async active-low reset
//   s_req_valid/_write     per-master request valid / write flag
//   s_req_addr/_wdata      per-master payload, master i at [i*W +: W]
//   s_req_ready            one-hot accept strobe (combinational, IDLE only)
//   s_rsp_valid/_rdata     one-hot completion pulse, read data (held)
//   m_transfer/_write/
//   m_addr/_wdata          command to the requester
//   m_rdata/m_ready        PRDATA / PREADY from the requester
//   busy, grant_id         not-IDLE flag, current or last granted master

// Per-master slot: unpacks one master's payload and raises its accept bit
// when it is the arbitration winner.
module apb_front_arbiter_slot #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IW  = 1,
  parameter int IDX = 0
) (
  input  logic          accept,
  input  logic [IW-1:0] win_id,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wdata_in,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic          ready
);
  assign addr  = addr_in;
  assign wdata = wdata_in;
  assign ready = accept && (win_id == IW'(IDX));
endmodule

module apb_front_arbiter #(
  parameter int NUM_MST    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_MST-1:0]            s_req_valid,
  input  logic [NUM_MST-1:0]            s_req_write,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] s_req_addr,
  input  logic [NUM_MST*DATA_WIDTH-1:0] s_req_wdata,
  output logic [NUM_MST-1:0]            s_req_ready,
  output logic [NUM_MST-1:0]            s_rsp_valid,
  output logic [DATA_WIDTH-1:0]         s_rsp_rdata,
  output logic                          m_transfer,
  output logic                          m_write,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_ready,
  output logic                          busy,
  output logic [$clog2(NUM_MST)-1:0]    grant_id
);
  localparam int IW = $clog2(NUM_MST);

  typedef enum logic [1:0] {IDLE, ISSUE, SETUP, ACCESS} state_t;

  state_t  state_q, state_d;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win_id;
  logic          win_vld;
  logic          accept;
  logic          done;

  logic [NUM_MST-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_MST-1:0][DATA_WIDTH-1:0] req_wdata;

  // Round-robin search starting at rr_ptr, wrapping at NUM_MST.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_MST;
      if (!win_vld && s_req_valid[IW'(idx)]) begin
        win_vld = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

  // Gate with PRESETn so no accept strobe leaks out while held in reset.
  assign accept = PRESETn && (state_q == IDLE) && win_vld;
  assign done   = (state_q == ACCESS) && m_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MST; gi++) begin : g_slot
      apb_front_arbiter_slot #(
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH),
        .IW (IW),
        .IDX(gi)
      ) u_slot (
        .accept  (accept),
        .win_id  (win_id),
        .addr_in (s_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
        .wdata_in(s_req_wdata[gi*DATA_WIDTH +: DATA_WIDTH]),
        .addr    (req_addr[gi]),
        .wdata   (req_wdata[gi]),
        .ready   (s_req_ready[gi])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state. SETUP ignores m_ready: a slave may hold PREADY high there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = ISSUE;
      ISSUE:   state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Registered command/response path. m_transfer is the registered accept,
  // so it is high only in ISSUE. The command holds until the next accept.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_transfer  <= 1'b0;
      m_write     <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      s_rsp_valid <= '0;
      s_rsp_rdata <= '0;
    end else begin
      m_transfer  <= accept;
      s_rsp_valid <= '0;
      if (accept) begin
        m_write  <= s_req_write[win_id];
        m_addr   <= req_addr[win_id];
        m_wdata  <= req_wdata[win_id];
        grant_id <= win_id;
        rr_ptr   <= (win_id == IW'(NUM_MST - 1)) ? '0 : win_id + 1'b1;
      end
      // Capture rdata on writes too; masters simply ignore it.
      if (done) begin
        s_rsp_valid <= NUM_MST'(1) << grant_id;
        s_rsp_rdata <= m_rdata;
      end
    end
  end
endmodule
